// File: rtl/instruction_decode_buffer_16bit_if.sv
// Fetch->decode->execute handshake bundle for the decode buffer.
// DECODE_ILLEGAL_TRAP_EN adds the illegal-opcode trap signals.
interface instruction_decode_buffer_16bit_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [15:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      out_opcode;
  logic [3:0]      out_rd;
  logic [3:0]      out_rs;
  logic [3:0]      out_rt;
  logic [15:0]     out_imm;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_is_branch;
  logic [CW-1:0]   occupancy;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            out_illegal;
  logic [7:0]      illegal_count;
`endif

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode,
    input  out_rd, out_rs, out_rt, out_imm,
    input  out_is_load, out_is_store, out_is_branch,
`ifdef DECODE_ILLEGAL_TRAP_EN
    input  out_illegal, illegal_count,
`endif
    input  occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_opcode,
    output out_rd, out_rs, out_rt, out_imm,
    output out_is_load, out_is_store, out_is_branch,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output out_illegal, illegal_count,
`endif
    output occupancy
  );
endinterface

// File: rtl/instruction_decode_buffer_16bit.sv
// Decode stage: decodes fetched instructions into a small FIFO skid buffer.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal opcode trap).
module instruction_decode_buffer_16bit #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
) (
  input logic clk,
  input logic reset,
  input logic flush,
  instruction_decode_buffer_16bit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      op;
    logic [3:0]      rd;
    logic [3:0]      rs;
    logic [3:0]      rt;
    logic [15:0]     imm;
    logic            ld;
    logic            st;
    logic            br;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        new_e;
  entry_t        head;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          push, pop;
  logic          vld;

  assign vld          = (count_q != '0);
  assign bus.in_ready = (count_q != CW'(DEPTH)) && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = vld && bus.out_ready;
  assign head         = mem_q[rd_ptr_q];

  // Split the incoming instruction into its stored fields.
  always_comb begin
    new_e     = '0;
    new_e.pc  = bus.in_pc;
    new_e.op  = bus.in_instr[15:12];
    new_e.rd  = bus.in_instr[11:8];
    new_e.rs  = bus.in_instr[7:4];
    new_e.rt  = bus.in_instr[3:0];
    new_e.imm = {{8{bus.in_instr[7]}}, bus.in_instr[7:0]};
    new_e.ld  = (bus.in_instr[15:12] == 4'hA);
    new_e.st  = (bus.in_instr[15:12] == 4'hB);
    new_e.br  = (bus.in_instr[15:12] == 4'hC);
  end

  // Next pointer/count state; flush wins over both handshakes.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Pointer, count and entry storage registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) mem_q[wr_ptr_q] <= new_e;
    end
  end

  assign bus.out_valid     = vld;
  assign bus.occupancy     = count_q;
  assign bus.out_pc        = vld ? head.pc  : '0;
  assign bus.out_opcode    = vld ? head.op  : '0;
  assign bus.out_rd        = vld ? head.rd  : '0;
  assign bus.out_rs        = vld ? head.rs  : '0;
  assign bus.out_rt        = vld ? head.rt  : '0;
  assign bus.out_imm       = vld ? head.imm : '0;
  assign bus.out_is_load   = vld && head.ld;
  assign bus.out_is_store  = vld && head.st;
  assign bus.out_is_branch = vld && head.br;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic [7:0] ill_cnt_q, ill_cnt_d;
  logic       ill;

  assign ill               = vld && (head.op[3:1] == 3'b111);
  assign bus.out_illegal   = ill;
  assign bus.illegal_count = ill_cnt_q;

  // Saturating count of illegal entries consumed by execute.
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (!flush && pop && ill && ill_cnt_q != 8'hFF)
      ill_cnt_d = ill_cnt_q + 8'd1;
  end

  // Illegal counter register; survives flush.
  always_ff @(posedge clk) begin
    if (!reset) ill_cnt_q <= '0;
    else        ill_cnt_q <= ill_cnt_d;
  end
`endif
endmodule

// File: tb/tb_instruction_decode_buffer_16bit.sv
// Directed bench for the decode skid buffer.
// Exercises the DECODE_ILLEGAL_TRAP_EN trap when that macro is defined.
module tb_instruction_decode_buffer_16bit;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  instruction_decode_buffer_16bit_if #(.DEPTH(2), .PC_W(16)) bus ();

  instruction_decode_buffer_16bit #(.DEPTH(2), .PC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] ins);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = ins;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %h want 0", bus.out_valid); end
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL rst_occ got %h want 0", bus.occupancy); end
    n_cmp++; if (bus.out_pc !== 16'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", bus.out_pc); end
    n_cmp++; if ({bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt} !== 16'h0) begin n_bad++; $display("FAIL rst_fields got %h want 0", {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt}); end
    n_cmp++; if (bus.out_imm !== 16'h0) begin n_bad++; $display("FAIL rst_imm got %h want 0", bus.out_imm); end
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %h want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid2 got %h want 0", bus.out_valid); end
  endtask

  task automatic test_decode;
    bus.out_ready = 1'b1;
    push(16'h0004, 16'hA35F);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL dec_no_bypass got %h want 0", bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL dec_valid got %h want 1", bus.out_valid); end
    n_cmp++; if (bus.out_pc !== 16'h0004) begin n_bad++; $display("FAIL dec_pc got %h want 0004", bus.out_pc); end
    n_cmp++; if ({bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt} !== 16'hA35F) begin n_bad++; $display("FAIL dec_fields got %h want a35f", {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt}); end
    n_cmp++; if (bus.out_imm !== 16'h005F) begin n_bad++; $display("FAIL dec_imm got %h want 005f", bus.out_imm); end
    n_cmp++; if ({bus.out_is_load, bus.out_is_store, bus.out_is_branch} !== 3'b100) begin n_bad++; $display("FAIL dec_flags got %b want 100", {bus.out_is_load, bus.out_is_store, bus.out_is_branch}); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_bad++; $display("FAIL dec_occ got %h want 1", bus.occupancy); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL dec_pop_valid got %h want 0", bus.out_valid); end
    n_cmp++; if (bus.out_pc !== 16'h0) begin n_bad++; $display("FAIL dec_idle_pc got %h want 0", bus.out_pc); end
  endtask

  task automatic test_stall;
    bus.out_ready = 1'b0;
    push(16'h0010, 16'hB123);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_bad++; $display("FAIL stl_occ1 got %h want 1", bus.occupancy); end
    n_cmp++; if (bus.out_is_store !== 1'b1) begin n_bad++; $display("FAIL stl_store got %h want 1", bus.out_is_store); end
    push(16'h0012, 16'hC9AB);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL stl_occ2 got %h want 2", bus.occupancy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stl_full_rdy got %h want 0", bus.in_ready); end
    push(16'h0014, 16'h1234);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL stl_occ_hold got %h want 2", bus.occupancy); end
    n_cmp++; if (bus.out_pc !== 16'h0010) begin n_bad++; $display("FAIL stl_head_pc got %h want 0010", bus.out_pc); end
    n_cmp++; if ({bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt} !== 16'hB123) begin n_bad++; $display("FAIL stl_head_fields got %h want b123", {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt}); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_pc !== 16'h0012) begin n_bad++; $display("FAIL stl_d1_pc got %h want 0012", bus.out_pc); end
    n_cmp++; if (bus.out_imm !== 16'hFFAB) begin n_bad++; $display("FAIL stl_d1_imm got %h want ffab", bus.out_imm); end
    n_cmp++; if ({bus.out_is_load, bus.out_is_store, bus.out_is_branch} !== 3'b001) begin n_bad++; $display("FAIL stl_d1_flags got %b want 001", {bus.out_is_load, bus.out_is_store, bus.out_is_branch}); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_bad++; $display("FAIL stl_d1_occ got %h want 1", bus.occupancy); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_pc !== 16'h0014) begin n_bad++; $display("FAIL stl_d2_pc got %h want 0014", bus.out_pc); end
    n_cmp++; if (bus.out_imm !== 16'h0034) begin n_bad++; $display("FAIL stl_d2_imm got %h want 0034", bus.out_imm); end
    tick();
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL stl_empty got %h want 0", bus.occupancy); end
  endtask

  task automatic test_push_pop;
    bus.out_ready = 1'b0;
    push(16'h0020, 16'h2222);
    tick();
    push(16'h0022, 16'h3456);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_bad++; $display("FAIL pp_occ got %h want 1", bus.occupancy); end
    n_cmp++; if (bus.out_pc !== 16'h0022) begin n_bad++; $display("FAIL pp_head_pc got %h want 0022", bus.out_pc); end
    n_cmp++; if ({bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt} !== 16'h3456) begin n_bad++; $display("FAIL pp_fields got %h want 3456", {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt}); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL pp_drain got %h want 0", bus.occupancy); end
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    push(16'h0030, 16'h4444);
    tick();
    push(16'h0032, 16'h5555);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL fl_full got %h want 2", bus.occupancy); end
    push(16'h0034, 16'h6666);
    flush = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_in_ready got %h want 0", bus.in_ready); end
    tick();
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL fl_occ got %h want 0", bus.occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got %h want 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_no_ghost got %h want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    push(16'h0040, 16'h7777);
    tick();
    push(16'h0042, 16'h8888);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL fl1_occ got %h want 0", bus.occupancy); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fl1_valid got %h want 0", bus.out_valid); end
  endtask

  task automatic test_opcode_e;
    bus.out_ready = 1'b0;
    push(16'h0050, 16'hE000);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_opcode !== 4'hE) begin n_bad++; $display("FAIL e_op got %h want e", bus.out_opcode); end
    n_cmp++; if ({bus.out_is_load, bus.out_is_store, bus.out_is_branch} !== 3'b000) begin n_bad++; $display("FAIL e_flags got %b want 000", {bus.out_is_load, bus.out_is_store, bus.out_is_branch}); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_cmp++; if (bus.out_illegal !== 1'b1) begin n_bad++; $display("FAIL e_illegal got %h want 1", bus.out_illegal); end
`endif
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL e_pop got %h want 0", bus.out_valid); end
  endtask

`ifdef DECODE_ILLEGAL_TRAP_EN
  task automatic test_illegal;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    push(16'h0060, 16'hF000);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_flag got %h want 1", bus.out_illegal); end
    n_cmp++; if (bus.illegal_count !== 8'd0) begin n_bad++; $display("FAIL ill_cnt0 got %h want 0", bus.illegal_count); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.illegal_count !== 8'd1) begin n_bad++; $display("FAIL ill_cnt1 got %h want 1", bus.illegal_count); end
    n_cmp++; if (bus.out_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_idle got %h want 0", bus.out_illegal); end
    bus.out_ready = 1'b0;
    push(16'h0062, 16'hF111);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (bus.illegal_count !== 8'd1) begin n_bad++; $display("FAIL ill_flush got %h want 1", bus.illegal_count); end
  endtask
`endif

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_decode();
    test_stall();
    test_push_pop();
    test_flush();
    test_opcode_e();
`ifdef DECODE_ILLEGAL_TRAP_EN
    test_illegal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
